// File: rtl/register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module   : register_file_pkg
// Brief    : Register-ID map and default geometry for the datapath register file.
// Revision : 1.0
// ============================================================================
package register_file_pkg;

    localparam int c_DEFAULT_WIDTH   = 8;
    localparam int c_DEFAULT_ID_BITS = 4;
    localparam int c_DEFAULT_COUNT   = 13;

    localparam logic [c_DEFAULT_ID_BITS-1:0] c_ID_R0  = 4'd0;
    localparam logic [c_DEFAULT_ID_BITS-1:0] c_ID_R1  = 4'd1;
    localparam logic [c_DEFAULT_ID_BITS-1:0] c_ID_R2  = 4'd2;
    localparam logic [c_DEFAULT_ID_BITS-1:0] c_ID_R3  = 4'd3;
    localparam logic [c_DEFAULT_ID_BITS-1:0] c_ID_R4  = 4'd4;
    localparam logic [c_DEFAULT_ID_BITS-1:0] c_ID_R5  = 4'd5;
    localparam logic [c_DEFAULT_ID_BITS-1:0] c_ID_R6  = 4'd6;
    localparam logic [c_DEFAULT_ID_BITS-1:0] c_ID_R7  = 4'd7;
    localparam logic [c_DEFAULT_ID_BITS-1:0] c_ID_R8  = 4'd8;
    localparam logic [c_DEFAULT_ID_BITS-1:0] c_ID_CMP = 4'd9;
    localparam logic [c_DEFAULT_ID_BITS-1:0] c_ID_SP  = 4'd10;
    localparam logic [c_DEFAULT_ID_BITS-1:0] c_ID_SF  = 4'd11;
    localparam logic [c_DEFAULT_ID_BITS-1:0] c_ID_PC  = 4'd12;

endpackage : register_file_pkg
`default_nettype wire

// File: rtl/register_file_if.sv
`default_nettype none
// ============================================================================
// Module   : register_file_if
// Brief    : Read/write/PC/SP bus between decode, ALU stage and the register file.
// Revision : 1.0
// ============================================================================
interface register_file_if #(
    parameter int WIDTH   = 8,
    parameter int ID_BITS = 4
);
    logic [ID_BITS-1:0] read1_id;
    logic [WIDTH-1:0]   read1_value;
    logic [ID_BITS-1:0] read2_id;
    logic [WIDTH-1:0]   read2_value;
    logic               write_en;
    logic [ID_BITS-1:0] write_id;
    logic [WIDTH-1:0]   write_value;
    logic               pc_inc;
    logic               sp_push;
    logic               sp_pop;
    logic               fault_clear;
    logic               sp_overflow;
    logic               sp_underflow;
    logic [WIDTH-1:0]   pc_value;

    modport master (
        output read1_id, read2_id, write_en, write_id, write_value,
               pc_inc, sp_push, sp_pop, fault_clear,
        input  read1_value, read2_value, sp_overflow, sp_underflow, pc_value
    );

    modport slave (
        input  read1_id, read2_id, write_en, write_id, write_value,
               pc_inc, sp_push, sp_pop, fault_clear,
        output read1_value, read2_value, sp_overflow, sp_underflow, pc_value
    );
endinterface : register_file_if
`default_nettype wire

// File: rtl/register_cell.sv
`default_nettype none
// ============================================================================
// Module   : register_cell
// Brief    : One WIDTH-bit register with async reset to RESET_VALUE and load enable.
// Revision : 1.0
// ============================================================================
module register_cell #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_load_en,
    input  wire logic [WIDTH-1:0] i_load_data,
    output logic      [WIDTH-1:0] o_value
);
    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= RESET_VALUE;
        end else if (i_load_en) begin
            r_value <= i_load_data;
        end
    end

    assign o_value = r_value;
endmodule : register_cell
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module   : register_file
// Brief    : 2R/1W register file with bypass, PC auto-increment and SP push/pop.
// Revision : 1.0
// ============================================================================
module register_file
    import register_file_pkg::*;
#(
    parameter int               WIDTH    = c_DEFAULT_WIDTH,
    parameter int               COUNT    = c_DEFAULT_COUNT,
    parameter int               ID_BITS  = c_DEFAULT_ID_BITS,
    parameter int               SP_ID    = int'(c_ID_SP),
    parameter int               PC_ID    = int'(c_ID_PC),
    parameter logic [WIDTH-1:0] SP_RESET = '1,
    parameter bit               BYPASS   = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    register_file_if.slave     bus
);
    localparam logic [WIDTH-1:0] c_ALL_ONES = '1;
    localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);

    logic [WIDTH-1:0] w_values [COUNT];

    logic             w_pc_write;
    logic             w_sp_write;
    logic             w_push_only;
    logic             w_pop_only;
    logic             w_sp_step;
    logic [WIDTH-1:0] w_sp_next;
    logic             w_overflow_event;
    logic             w_underflow_event;

    logic             r_sp_overflow;
    logic             r_sp_underflow;

    // An explicit write to PC/SP overrides any increment or stack step that cycle.
    assign w_pc_write  = bus.write_en && (bus.write_id == ID_BITS'(PC_ID));
    assign w_sp_write  = bus.write_en && (bus.write_id == ID_BITS'(SP_ID));
    assign w_push_only = bus.sp_push && !bus.sp_pop;
    assign w_pop_only  = bus.sp_pop  && !bus.sp_push;

    assign w_overflow_event  = !w_sp_write && w_push_only && (w_values[SP_ID] == '0);
    assign w_underflow_event = !w_sp_write && w_pop_only  && (w_values[SP_ID] == c_ALL_ONES);
    assign w_sp_step         = !w_sp_write
                             && ((w_push_only && (w_values[SP_ID] != '0))
                              || (w_pop_only  && (w_values[SP_ID] != c_ALL_ONES)));
    assign w_sp_next         = w_push_only ? (w_values[SP_ID] - c_ONE)
                                           : (w_values[SP_ID] + c_ONE);

    generate
        for (genvar gi = 0; gi < COUNT; gi++) begin : g_cells
            logic             w_en;
            logic [WIDTH-1:0] w_data;

            if (gi == PC_ID) begin : g_pc
                assign w_en   = w_pc_write || bus.pc_inc;
                assign w_data = w_pc_write ? bus.write_value : (w_values[gi] + c_ONE);
            end else if (gi == SP_ID) begin : g_sp
                assign w_en   = w_sp_write || w_sp_step;
                assign w_data = w_sp_write ? bus.write_value : w_sp_next;
            end else begin : g_gpr
                assign w_en   = bus.write_en && (bus.write_id == ID_BITS'(gi));
                assign w_data = bus.write_value;
            end

            register_cell #(
                .WIDTH       (WIDTH),
                .RESET_VALUE ((gi == SP_ID) ? SP_RESET : '0)
            ) u_cell (
                .clk         (clk),
                .reset       (reset),
                .i_load_en   (w_en),
                .i_load_data (w_data),
                .o_value     (w_values[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp_overflow  <= 1'b0;
            r_sp_underflow <= 1'b0;
        end else begin
            r_sp_overflow  <= (r_sp_overflow  && !bus.fault_clear) || w_overflow_event;
            r_sp_underflow <= (r_sp_underflow && !bus.fault_clear) || w_underflow_event;
        end
    end

    // Unimplemented IDs never match the loop, so they read 0 and never bypass.
    always_comb begin
        bus.read1_value = '0;
        bus.read2_value = '0;
        for (int i = 0; i < COUNT; i++) begin
            if (bus.read1_id == ID_BITS'(i)) begin
                bus.read1_value = (BYPASS && bus.write_en && (bus.write_id == ID_BITS'(i)))
                                ? bus.write_value : w_values[i];
            end
            if (bus.read2_id == ID_BITS'(i)) begin
                bus.read2_value = (BYPASS && bus.write_en && (bus.write_id == ID_BITS'(i)))
                                ? bus.write_value : w_values[i];
            end
        end
    end

    assign bus.pc_value     = w_values[PC_ID];
    assign bus.sp_overflow  = r_sp_overflow;
    assign bus.sp_underflow = r_sp_underflow;
endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file
// Brief    : Directed vector bench for register_file (8-bit, 13 regs, bypass on).
// Revision : 1.0
// ============================================================================
module tb_register_file;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    register_file_if #(.WIDTH(8), .ID_BITS(4)) bus ();

    register_file #(
        .WIDTH    (8),
        .COUNT    (13),
        .ID_BITS  (4),
        .SP_ID    (10),
        .PC_ID    (12),
        .SP_RESET (8'hFF),
        .BYPASS   (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       we;
        logic [3:0] wid;
        logic [7:0] wval;
        logic       inc;
        logic       push;
        logic       pop;
        logic       clr;
        logic [3:0] r1;
        logic [3:0] r2;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] epc;
        logic       eovf;
        logic       eunf;
    } vec_t;

    localparam int c_NVEC = 17;
    vec_t vecs [c_NVEC];

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(logic we, logic [3:0] wid, logic [7:0] wval,
                                logic inc, logic push, logic pop, logic clr,
                                logic [3:0] r1, logic [3:0] r2,
                                logic [7:0] e1, logic [7:0] e2, logic [7:0] epc,
                                logic eovf, logic eunf);
        vec_t v;
        v.we = we; v.wid = wid; v.wval = wval;
        v.inc = inc; v.push = push; v.pop = pop; v.clr = clr;
        v.r1 = r1; v.r2 = r2; v.e1 = e1; v.e2 = e2; v.epc = epc;
        v.eovf = eovf; v.eunf = eunf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.write_en    = 1'b0;
        bus.write_id    = '0;
        bus.write_value = '0;
        bus.pc_inc      = 1'b0;
        bus.sp_push     = 1'b0;
        bus.sp_pop      = 1'b0;
        bus.fault_clear = 1'b0;
        bus.read1_id    = '0;
        bus.read2_id    = '0;
    endtask

    initial begin
        //            we  wid    wval   inc push pop clr r1     r2     e1     e2     epc    ovf unf
        vecs[0]  = mk(1, 4'd3,  8'h5A, 0, 0, 0, 0, 4'd3,  4'd0,  8'h5A, 8'h00, 8'h00, 0, 0);
        vecs[1]  = mk(1, 4'd14, 8'h77, 0, 0, 0, 0, 4'd3,  4'd14, 8'h5A, 8'h00, 8'h00, 0, 0);
        vecs[2]  = mk(1, 4'd12, 8'hFE, 0, 0, 0, 0, 4'd14, 4'd3,  8'h00, 8'h5A, 8'h00, 0, 0);
        vecs[3]  = mk(0, 4'd0,  8'h00, 1, 0, 0, 0, 4'd12, 4'd0,  8'hFE, 8'h00, 8'hFE, 0, 0);
        vecs[4]  = mk(0, 4'd0,  8'h00, 1, 0, 0, 0, 4'd12, 4'd10, 8'hFF, 8'hFF, 8'hFF, 0, 0);
        vecs[5]  = mk(0, 4'd0,  8'h00, 1, 0, 0, 0, 4'd12, 4'd3,  8'h00, 8'h5A, 8'h00, 0, 0);
        vecs[6]  = mk(1, 4'd12, 8'h40, 1, 0, 0, 0, 4'd12, 4'd3,  8'h40, 8'h5A, 8'h01, 0, 0);
        vecs[7]  = mk(0, 4'd0,  8'h00, 0, 0, 1, 0, 4'd12, 4'd10, 8'h40, 8'hFF, 8'h40, 0, 0);
        vecs[8]  = mk(0, 4'd0,  8'h00, 0, 1, 0, 0, 4'd10, 4'd12, 8'hFF, 8'h40, 8'h40, 0, 1);
        vecs[9]  = mk(0, 4'd0,  8'h00, 0, 1, 0, 0, 4'd10, 4'd0,  8'hFE, 8'h00, 8'h40, 0, 1);
        vecs[10] = mk(0, 4'd0,  8'h00, 0, 0, 0, 1, 4'd10, 4'd0,  8'hFD, 8'h00, 8'h40, 0, 1);
        vecs[11] = mk(0, 4'd0,  8'h00, 0, 1, 1, 0, 4'd10, 4'd0,  8'hFD, 8'h00, 8'h40, 0, 0);
        vecs[12] = mk(1, 4'd10, 8'h00, 0, 0, 0, 0, 4'd10, 4'd10, 8'h00, 8'h00, 8'h40, 0, 0);
        vecs[13] = mk(0, 4'd0,  8'h00, 0, 1, 0, 0, 4'd10, 4'd3,  8'h00, 8'h5A, 8'h40, 0, 0);
        vecs[14] = mk(0, 4'd0,  8'h00, 0, 1, 0, 1, 4'd10, 4'd0,  8'h00, 8'h00, 8'h40, 1, 0);
        vecs[15] = mk(1, 4'd10, 8'h07, 0, 1, 0, 0, 4'd10, 4'd12, 8'h07, 8'h40, 8'h40, 1, 0);
        vecs[16] = mk(0, 4'd0,  8'h00, 0, 0, 0, 0, 4'd10, 4'd3,  8'h07, 8'h5A, 8'h40, 1, 0);

        drive_idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Reset contents of every ID, including unimplemented ones
        for (int id = 0; id < 16; id++) begin
            bus.read1_id = 4'(id);
            bus.read2_id = 4'(15 - id);
            #1;
            chk($sformatf("reset_r1_id%0d", id), bus.read1_value, (id == 10) ? 8'hFF : 8'h00);
            chk($sformatf("reset_r2_id%0d", 15 - id), bus.read2_value,
                ((15 - id) == 10) ? 8'hFF : 8'h00);
        end
        chk("reset_ovf", {7'd0, bus.sp_overflow}, 8'h00);
        chk("reset_unf", {7'd0, bus.sp_underflow}, 8'h00);
        chk("reset_pc", bus.pc_value, 8'h00);

        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < c_NVEC; v++) begin
            @(negedge clk);
            bus.write_en    = vecs[v].we;
            bus.write_id    = vecs[v].wid;
            bus.write_value = vecs[v].wval;
            bus.pc_inc      = vecs[v].inc;
            bus.sp_push     = vecs[v].push;
            bus.sp_pop      = vecs[v].pop;
            bus.fault_clear = vecs[v].clr;
            bus.read1_id    = vecs[v].r1;
            bus.read2_id    = vecs[v].r2;
            #1;
            chk($sformatf("v%0d_read1", v), bus.read1_value, vecs[v].e1);
            chk($sformatf("v%0d_read2", v), bus.read2_value, vecs[v].e2);
            chk($sformatf("v%0d_pc", v), bus.pc_value, vecs[v].epc);
            chk($sformatf("v%0d_ovf", v), {7'd0, bus.sp_overflow}, {7'd0, vecs[v].eovf});
            chk($sformatf("v%0d_unf", v), {7'd0, bus.sp_underflow}, {7'd0, vecs[v].eunf});
        end

        // Re-create an overflow, then reset asynchronously between edges
        @(negedge clk);
        drive_idle();
        bus.write_en = 1'b1;
        bus.write_id = 4'd10;
        bus.write_value = 8'h00;
        @(negedge clk);
        drive_idle();
        bus.sp_push = 1'b1;
        @(negedge clk);
        drive_idle();
        bus.read1_id = 4'd10;
        bus.read2_id = 4'd3;
        #1;
        chk("pre_areset_ovf", {7'd0, bus.sp_overflow}, 8'h01);
        chk("pre_areset_sp", bus.read1_value, 8'h00);
        #1;
        reset = 1'b1;
        #1;
        chk("areset_sp", bus.read1_value, 8'hFF);
        chk("areset_r3", bus.read2_value, 8'h00);
        chk("areset_ovf", {7'd0, bus.sp_overflow}, 8'h00);
        chk("areset_pc", bus.pc_value, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // First edge after release acts on inputs present
        bus.pc_inc = 1'b1;
        @(negedge clk);
        bus.pc_inc = 1'b0;
        #1;
        chk("post_reset_pc", bus.pc_value, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule : tb_register_file
`default_nettype wire

// File: doc/register_file.md
# register_file

Clocked, parametrised general-purpose register file for the CPU datapath: two combinational read ports and one synchronous write port, with ID decode folded in. Replaces the fixed 13×8 level-enabled block and adds write enable, read-after-write bypass, program-counter auto-increment and stack-pointer push/pop with sticky fault flags. Sits between instruction decode (register IDs) and the ALU/memory stage (operand values, write-back).

## Interface
- `WIDTH`, 8, data width of every register
- `COUNT`, 13, number of implemented registers; IDs `COUNT..2**ID_BITS-1` are unimplemented
- `ID_BITS`, 4, register-ID width; `COUNT <= 2**ID_BITS` is required
- `SP_ID`, 10, ID of the stack-pointer register
- `PC_ID`, 12, ID of the program-counter register
- `SP_RESET`, all-ones of WIDTH, stack-pointer value after reset
- `BYPASS`, 1, 1 = read ports forward same-cycle write data
- `clk` in 1 — rising-edge clock
- `reset` in 1 — asynchronous, active-high; all state is cleared while it is high
- `read1_id` in ID_BITS — read port 1 select
- `read1_value` out WIDTH — read port 1 data
- `read2_id` in ID_BITS — read port 2 select
- `read2_value` out WIDTH — read port 2 data
- `write_en` in 1 — write strobe
- `write_id` in ID_BITS — write target
- `write_value` in WIDTH — write data
- `pc_inc` in 1 — increment PC by 1 this cycle
- `sp_push` in 1 — decrement SP by 1 this cycle
- `sp_pop` in 1 — increment SP by 1 this cycle
- `fault_clear` in 1 — clear the sticky fault flags
- `sp_overflow` out 1 — sticky: push attempted with SP == 0
- `sp_underflow` out 1 — sticky: pop attempted with SP == all-ones
- `pc_value` out WIDTH — direct PC tap for instruction fetch

## Operation
- Reset: every register is 0, except SP, which is `SP_RESET`. Both fault flags are 0. Reads reflect those values immediately; the reset is asynchronous.
- Read: `readN_value` = contents of register `readN_id`. An unimplemented ID reads 0.
- Bypass: with `BYPASS=1`, when `write_en` is high and `write_id == readN_id` (implemented), `readN_value = write_value` in the same cycle. With `BYPASS=0` the read returns the stored value.
- Write: on the edge with `write_en` high, the register at `write_id` takes `write_value`. A write to an unimplemented ID is dropped with no side effect.
- PC: on an edge with `pc_inc` high, PC takes PC+1 modulo 2^WIDTH. Wrap from all-ones to 0 is silent.
- SP:
  - push: SP takes SP−1.
  - pop: SP takes SP+1.
  - Push at SP == 0 leaves SP unchanged and sets `sp_overflow`.
  - Pop at SP == all-ones leaves SP unchanged and sets `sp_underflow`.
- Priority on PC/SP in one cycle:
  - An explicit write to that ID wins over `pc_inc`, push and pop. The increment or step is discarded and no fault is raised.
  - `sp_push` and `sp_pop` together give no SP change and no fault.
- Faults:
  - A flag, once set, holds until `fault_clear` or `reset`.
  - If `fault_clear` and a new fault occur on the same edge, the flag ends up set.
- `pc_value` is the stored PC, not bypassed.
- Reads of PC/SP through the read ports return the stored value. Bypass applies only to `write_en` writes, never to increments.

## Timing
- Read ports: combinational, zero-cycle latency from `readN_id`, stored state and bypass inputs.
- Write, PC increment, SP step and flags: updated on the rising edge. Results are visible on reads in the following cycle.
- Reset asserted mid-operation clears state at once, regardless of clk. The first edge after deassertion acts normally on the inputs present.
- No handshake. Every strobe is single-cycle qualified, and holding a strobe high repeats its action each cycle.

## Structure
- Shared package `register_file_pkg`:
  - register-ID constants (R0..R8, CMP=9, SP=10, SF=11, PC=12)
  - default `WIDTH`/`ID_BITS`
- Sub-module `register_cell`: one WIDTH-bit flop with async reset to a parameter value, load enable and load data. The top generates `COUNT` instances.
- PC and SP next-value muxing, the fault logic and the bypass compare live in the top.

## Test plan
- Reset, then read all 16 IDs: 0 for IDs 0–9, 11 and 12; 0xFF for ID 10; 0 for IDs 13–15. Both fault flags are 0.
- `write_en=1`, `write_id=3`, `write_value=0x5A`, `read1_id=3`: `read1_value=0x5A` in the same cycle with `BYPASS=1`. Next cycle, with `write_en=0`, it is still 0x5A. A write to ID 14 changes nothing.
- Set PC to 0xFE, then `pc_inc` ×3 → PC is 0xFF, then 0x00, then 0x01. On the next cycle, `pc_inc` together with a write of 0x40 to ID 12 gives PC = 0x40.
- SP at reset value 0xFF: `sp_pop` → SP stays 0xFF and `sp_underflow` = 1. `sp_push` ×2 → SP = 0xFD. `fault_clear` → underflow = 0. `sp_push` and `sp_pop` together → SP stays 0xFD.
- Write SP = 0x00, then `sp_push` → `sp_overflow` = 1 and SP stays 0x00. Assert `reset` between clock edges → SP reads 0xFF and the flag reads 0 at once, with no edge needed.
